// File: rtl/box_overlay_multi.sv
// ============================================================================
// box_overlay_multi: up to NUM_BOXES rectangle outlines over a pixel stream.
// Revision: 1.0
// ============================================================================
`default_nettype none

module box_overlay_multi #(
    parameter int NUM_BOXES = 4,
    parameter int COORD_W   = 11,
    parameter int X_OFFSET  = 320,
    parameter int Y_OFFSET  = 45,
    parameter int IDX_W     = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [19:0]        dot,
    input  logic [19:0]        y_count_in,
    input  logic               pix_valid_in,
    input  logic               frame_start,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [COORD_W-1:0] wr_x1,
    input  logic [COORD_W-1:0] wr_y1,
    input  logic [COORD_W-1:0] wr_x2,
    input  logic [COORD_W-1:0] wr_y2,
    input  logic [2:0]         wr_rgb,
    input  logic [1:0]         wr_thick,
    input  logic               wr_en,
    output logic               pix_valid_out,
    output logic               flag_out,
    output logic [2:0]         rgb_out,
    output logic [IDX_W-1:0]   hit_idx
);

    localparam int c_ext_w = COORD_W + 1;

    logic [COORD_W-1:0] r_sh_x1  [NUM_BOXES];
    logic [COORD_W-1:0] r_sh_y1  [NUM_BOXES];
    logic [COORD_W-1:0] r_sh_x2  [NUM_BOXES];
    logic [COORD_W-1:0] r_sh_y2  [NUM_BOXES];
    logic [2:0]         r_sh_rgb [NUM_BOXES];
    logic [1:0]         r_sh_th  [NUM_BOXES];
    logic               r_sh_en  [NUM_BOXES];

    logic [COORD_W-1:0] r_act_x1  [NUM_BOXES];
    logic [COORD_W-1:0] r_act_y1  [NUM_BOXES];
    logic [COORD_W-1:0] r_act_x2  [NUM_BOXES];
    logic [COORD_W-1:0] r_act_y2  [NUM_BOXES];
    logic [2:0]         r_act_rgb [NUM_BOXES];
    logic [1:0]         r_act_th  [NUM_BOXES];
    logic               r_act_en  [NUM_BOXES];

    logic [COORD_W-1:0] r_px;
    logic [COORD_W-1:0] r_py;
    logic               r_v1;

    logic [NUM_BOXES-1:0] w_hit;
    logic                 w_flag;
    logic [2:0]           w_rgb;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_unused;

    assign w_unused = ^{dot[19:COORD_W], y_count_in[19:COORD_W]};

    // Blocking writes on the commit cycle keeps shadow and active updates disjoint.
    assign wr_ready = ~frame_start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_BOXES; i++) begin
                r_sh_x1[i]   <= '0;
                r_sh_y1[i]   <= '0;
                r_sh_x2[i]   <= '0;
                r_sh_y2[i]   <= '0;
                r_sh_rgb[i]  <= '0;
                r_sh_th[i]   <= '0;
                r_sh_en[i]   <= 1'b0;
                r_act_x1[i]  <= '0;
                r_act_y1[i]  <= '0;
                r_act_x2[i]  <= '0;
                r_act_y2[i]  <= '0;
                r_act_rgb[i] <= '0;
                r_act_th[i]  <= '0;
                r_act_en[i]  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_BOXES; i++) begin
                // Out-of-range indices match no slot and are silently dropped.
                if (wr_valid && wr_ready && (wr_idx == IDX_W'(i))) begin
                    r_sh_x1[i]  <= wr_x1;
                    r_sh_y1[i]  <= wr_y1;
                    r_sh_x2[i]  <= wr_x2;
                    r_sh_y2[i]  <= wr_y2;
                    r_sh_rgb[i] <= wr_rgb;
                    r_sh_th[i]  <= wr_thick;
                    r_sh_en[i]  <= wr_en;
                end
                if (frame_start) begin
                    r_act_x1[i]  <= r_sh_x1[i];
                    r_act_y1[i]  <= r_sh_y1[i];
                    r_act_x2[i]  <= r_sh_x2[i];
                    r_act_y2[i]  <= r_sh_y2[i];
                    r_act_rgb[i] <= r_sh_rgb[i];
                    r_act_th[i]  <= r_sh_th[i];
                    r_act_en[i]  <= r_sh_en[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_px <= '0;
            r_py <= '0;
            r_v1 <= 1'b0;
        end else begin
            r_px <= dot[COORD_W-1:0] - COORD_W'(X_OFFSET);
            r_py <= y_count_in[COORD_W-1:0] - COORD_W'(Y_OFFSET);
            r_v1 <= pix_valid_in;
        end
    end

    for (genvar gi = 0; gi < NUM_BOXES; gi++) begin : g_slot
        logic [c_ext_w-1:0] w_px, w_py, w_x1, w_y1, w_x2, w_y2, w_t;
        logic               w_inside, w_edge;

        assign w_px = {1'b0, r_px};
        assign w_py = {1'b0, r_py};
        assign w_x1 = {1'b0, r_act_x1[gi]};
        assign w_y1 = {1'b0, r_act_y1[gi]};
        assign w_x2 = {1'b0, r_act_x2[gi]};
        assign w_y2 = {1'b0, r_act_y2[gi]};
        assign w_t  = {{(c_ext_w-2){1'b0}}, r_act_th[gi]} + {{(c_ext_w-1){1'b0}}, 1'b1};

        // Degenerate boxes fall out here: no px satisfies x1 <= px <= x2.
        assign w_inside = (w_px >= w_x1) && (w_px <= w_x2) && (w_py >= w_y1) && (w_py <= w_y2);
        // px > x2-t is written as px+t > x2 so a small x2 cannot underflow.
        assign w_edge   = (w_px < w_x1 + w_t) || (w_px + w_t > w_x2) ||
                          (w_py < w_y1 + w_t) || (w_py + w_t > w_y2);
        assign w_hit[gi] = r_act_en[gi] && w_inside && w_edge && r_v1;
    end

    always_comb begin
        w_flag = 1'b0;
        w_rgb  = '0;
        w_idx  = '0;
        for (int i = NUM_BOXES - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_flag = 1'b1;
                w_rgb  = r_act_rgb[i];
                w_idx  = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_valid_out <= 1'b0;
            flag_out      <= 1'b0;
            rgb_out       <= '0;
            hit_idx       <= '0;
        end else begin
            pix_valid_out <= r_v1;
            flag_out      <= w_flag;
            rgb_out       <= w_rgb;
            hit_idx       <= w_idx;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_box_overlay_multi.sv
// ============================================================================
// tb_box_overlay_multi: directed tables plus randomized model-checked pixels.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_box_overlay_multi;

    localparam int NB = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] dot, y_count_in;
    logic        pix_valid_in, frame_start, wr_valid, wr_ready;
    logic [1:0]  wr_idx;
    logic [10:0] wr_x1, wr_y1, wr_x2, wr_y2;
    logic [2:0]  wr_rgb;
    logic [1:0]  wr_thick;
    logic        wr_en;
    logic        pix_valid_out, flag_out;
    logic [2:0]  rgb_out;
    logic [1:0]  hit_idx;

    box_overlay_multi #(.NUM_BOXES(NB), .COORD_W(11), .X_OFFSET(320),
                        .Y_OFFSET(45), .IDX_W(2)) dut (
        .clk(clk), .reset(reset), .dot(dot), .y_count_in(y_count_in),
        .pix_valid_in(pix_valid_in), .frame_start(frame_start),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_idx(wr_idx),
        .wr_x1(wr_x1), .wr_y1(wr_y1), .wr_x2(wr_x2), .wr_y2(wr_y2),
        .wr_rgb(wr_rgb), .wr_thick(wr_thick), .wr_en(wr_en),
        .pix_valid_out(pix_valid_out), .flag_out(flag_out),
        .rgb_out(rgb_out), .hit_idx(hit_idx)
    );

    always #5 clk = ~clk;

    typedef struct { int x1; int y1; int x2; int y2; int rgb; int th; int en; } box_t;
    typedef struct { int d; int y; bit v; logic [6:0] e; } vec_t;

    box_t sh[NB];
    box_t act[NB];
    logic [6:0] eq[$];
    string      nq[$];
    vec_t       tv[$];
    int passed = 0;
    int total  = 0;

    function automatic logic [6:0] outs();
        return {pix_valid_out, flag_out, rgb_out, hit_idx};
    endfunction

    // Expected {valid, flag, rgb, idx}: first enabled slot whose outline contains the pixel.
    function automatic logic [6:0] model(int d, int y, bit v);
        int px = ((d % 2048) - 320 + 2048) % 2048;
        int py = ((y % 2048) - 45 + 2048) % 2048;
        for (int i = 0; i < NB; i++) begin
            int t = act[i].th + 1;
            if (v && act[i].en != 0 &&
                px >= act[i].x1 && px <= act[i].x2 && py >= act[i].y1 && py <= act[i].y2 &&
                (px < act[i].x1 + t || px > act[i].x2 - t || py < act[i].y1 + t || py > act[i].y2 - t))
                return {1'b1, 1'b1, 3'(act[i].rgb), 2'(i)};
        end
        return {v, 6'b0};
    endfunction

    task automatic check(string nm, logic [7:0] got, logic [7:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Each drive checks the output belonging to the pixel applied two cycles earlier.
    task automatic drive(int d, int y, bit v, logic [6:0] e, string nm);
        dot = 20'(d);
        y_count_in = 20'(y);
        pix_valid_in = v;
        eq.push_back(e);
        nq.push_back(nm);
        tick();
        if (eq.size() >= 2) check(nq.pop_front(), {1'b0, outs()}, {1'b0, eq.pop_front()});
    endtask

    task automatic drive_m(int d, int y, bit v, string nm);
        drive(d, y, v, model(d, y, v), nm);
    endtask

    task automatic flush();
        drive(0, 0, 1'b0, 7'b0, "idle");
        drive(0, 0, 1'b0, 7'b0, "idle");
        pix_valid_in = 1'b0;
        eq.delete();
        nq.delete();
    endtask

    task automatic set_wr(int idx, int x1, int y1, int x2, int y2, int rgb, int th, int en);
        wr_idx = 2'(idx); wr_x1 = 11'(x1); wr_y1 = 11'(y1); wr_x2 = 11'(x2); wr_y2 = 11'(y2);
        wr_rgb = 3'(rgb); wr_thick = 2'(th); wr_en = 1'(en);
    endtask

    task automatic do_write(int idx, int x1, int y1, int x2, int y2, int rgb, int th, int en);
        set_wr(idx, x1, y1, x2, y2, rgb, th, en);
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        if (idx < NB) sh[idx] = '{x1, y1, x2, y2, rgb, th, en};
    endtask

    task automatic commit();
        frame_start = 1'b1;
        #1;
        check("wr_ready_commit", {7'b0, wr_ready}, 8'h00);
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        act = sh;
    endtask

    task automatic run_table(string nm);
        foreach (tv[k]) drive(tv[k].d, tv[k].y, tv[k].v, tv[k].e, nm);
        flush();
        tv.delete();
    endtask

    initial begin
        reset = 1'b1;
        dot = '0; y_count_in = '0; pix_valid_in = 1'b0; frame_start = 1'b0; wr_valid = 1'b0;
        set_wr(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < NB; i++) sh[i] = '{0, 0, 0, 0, 0, 0, 0};
        act = sh;
        tick(); tick();
        check("reset_state", {outs(), wr_ready}, 8'h01);
        reset = 1'b0;
        tick();

        // Single box, 1 px border: top row fully lit, mid row only at the side edges.
        do_write(0, 10, 10, 20, 15, 3'b100, 0, 1);
        commit();
        tv.push_back('{329, 55, 1'b1, 7'b1000000});
        tv.push_back('{330, 55, 1'b1, 7'b1110000});
        tv.push_back('{335, 55, 1'b1, 7'b1110000});
        tv.push_back('{340, 55, 1'b1, 7'b1110000});
        tv.push_back('{341, 55, 1'b1, 7'b1000000});
        tv.push_back('{330, 57, 1'b1, 7'b1110000});
        tv.push_back('{331, 57, 1'b1, 7'b1000000});
        tv.push_back('{340, 57, 1'b1, 7'b1110000});
        tv.push_back('{335, 60, 1'b1, 7'b1110000});
        tv.push_back('{335, 61, 1'b1, 7'b1000000});
        tv.push_back('{335, 55, 1'b0, 7'b0000000});
        tv.push_back('{330, 55, 1'b1, 7'b1110000});
        run_table("single_box");

        // Shadow write without commit stays invisible.
        do_write(0, 40, 40, 60, 60, 3'b010, 0, 1);
        drive(360, 85, 1'b1, 7'b1000000, "no_commit");
        drive(330, 55, 1'b1, 7'b1110000, "old_active");
        flush();
        commit();
        drive(360, 85, 1'b1, 7'b1101000, "after_commit");
        flush();

        // Write raised on the frame_start cycle waits one cycle.
        set_wr(1, 200, 200, 210, 210, 3'b111, 1, 1);
        wr_valid = 1'b1;
        frame_start = 1'b1;
        #1;
        check("wr_ready_fs", {7'b0, wr_ready}, 8'h00);
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        act = sh;
        #1;
        check("wr_ready_after_fs", {7'b0, wr_ready}, 8'h01);
        tick();
        wr_valid = 1'b0;
        sh[1] = '{200, 200, 210, 210, 7, 1, 1};
        drive(520, 245, 1'b1, 7'b1000000, "delayed_write_pending");
        flush();
        commit();
        drive(520, 245, 1'b1, 7'b1111101, "delayed_write_commit");
        flush();

        // Overlap priority.
        do_write(0, 0, 0, 50, 50, 3'b001, 0, 1);
        do_write(1, 0, 0, 0, 0, 0, 0, 0);
        do_write(2, 0, 0, 30, 30, 3'b010, 0, 1);
        commit();
        tv.push_back('{320, 45, 1'b1, 7'b1100100});
        tv.push_back('{350, 55, 1'b1, 7'b1101010});
        tv.push_back('{340, 55, 1'b1, 7'b1000000});
        tv.push_back('{370, 60, 1'b1, 7'b1100100});
        run_table("overlap");

        // Thickness, degenerate box, disabled slot.
        do_write(0, 5, 5, 3, 9, 3'b111, 3, 1);
        do_write(1, 100, 100, 120, 120, 3'b101, 2, 1);
        do_write(2, 100, 100, 120, 120, 3'b011, 0, 0);
        commit();
        tv.push_back('{420, 155, 1'b1, 7'b1110101});
        tv.push_back('{421, 155, 1'b1, 7'b1110101});
        tv.push_back('{422, 155, 1'b1, 7'b1110101});
        tv.push_back('{423, 155, 1'b1, 7'b1000000});
        tv.push_back('{437, 155, 1'b1, 7'b1000000});
        tv.push_back('{438, 155, 1'b1, 7'b1110101});
        tv.push_back('{440, 155, 1'b1, 7'b1110101});
        tv.push_back('{324, 51, 1'b1, 7'b1000000});
        tv.push_back('{325, 50, 1'b1, 7'b1000000});
        run_table("thick_degen");

        // Out-of-range slot index is dropped; valid toggling follows with 2 cycles delay.
        do_write(3, 0, 0, 2047, 2047, 3'b111, 3, 1);
        commit();
        tv.push_back('{320, 45, 1'b1, 7'b1000000});
        tv.push_back('{420, 145, 1'b1, 7'b1110101});
        tv.push_back('{420, 145, 1'b0, 7'b0000000});
        tv.push_back('{420, 145, 1'b1, 7'b1110101});
        tv.push_back('{420, 145, 1'b0, 7'b0000000});
        run_table("drop_and_valid");

        // Randomized boxes and pixels against the model.
        for (int r = 0; r < 12; r++) begin
            for (int w = 0; w < 4; w++)
                do_write($urandom_range(0, 3), $urandom_range(0, 100), $urandom_range(0, 100),
                         $urandom_range(0, 130), $urandom_range(0, 130), $urandom_range(0, 7),
                         $urandom_range(0, 3), ($urandom_range(0, 3) != 0) ? 1 : 0);
            commit();
            for (int p = 0; p < 60; p++) begin
                if ($urandom_range(0, 9) == 0)
                    drive_m($urandom_range(0, 20'hFFFFF), $urandom_range(0, 20'hFFFFF),
                            1'($urandom_range(0, 1)), "rand_wide");
                else
                    drive_m(320 + $urandom_range(0, 135), 45 + $urandom_range(0, 135),
                            ($urandom_range(0, 3) != 0), "rand_pix");
            end
            flush();
        end

        // Asynchronous reset mid-scan.
        do_write(0, 10, 10, 20, 15, 3'b100, 0, 1);
        commit();
        drive(330, 55, 1'b1, 7'b1110000, "pre_reset");
        drive(330, 55, 1'b1, 7'b1110000, "pre_reset");
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_out", {outs(), wr_ready}, 8'h01);
        tick();
        reset = 1'b0;
        eq.delete();
        nq.delete();
        for (int i = 0; i < NB; i++) sh[i] = '{0, 0, 0, 0, 0, 0, 0};
        act = sh;
        for (int k = 0; k < 4; k++) drive(330, 55, 1'b1, 7'b1000000, "post_reset");
        flush();
        do_write(0, 10, 10, 20, 15, 3'b100, 0, 1);
        drive(330, 55, 1'b1, 7'b1000000, "post_reset_nocommit");
        flush();
        commit();
        drive(330, 55, 1'b1, 7'b1110000, "post_reset_rewrite");
        flush();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/box_overlay_multi.md
Name: box_overlay_multi

Overview:
- Parametrised successor to the single-box outline generator in the camera-to-VGA path.
- Draws up to NUM_BOXES rectangle outlines, each with its own colour, enable and border thickness, over the live pixel stream.
- Box coordinates load through a valid/ready write port into shadow registers and become active only at frame start, so a box never tears mid-frame.
- Pixel path is a registered 2-stage pipeline that feeds the VGA colour mux.

Parameters:
- NUM_BOXES, 4, number of box slots (1..16).
- COORD_W, 11, width of box coordinates and of the offset-corrected pixel position.
- X_OFFSET, 320, subtracted from dot[COORD_W-1:0] to get the active-area x.
- Y_OFFSET, 45, subtracted from y_count_in[COORD_W-1:0] to get the active-area y.
- IDX_W, 2, width of the slot index (must be >= clog2(NUM_BOXES), minimum 1).

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- dot  in  20  horizontal pixel counter
- y_count_in  in  20  line counter
- pix_valid_in  in  1  dot/y_count_in are valid this cycle
- frame_start  in  1  one-cycle pulse at the start of vertical blanking
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- wr_idx  in  IDX_W  target slot
- wr_x1, wr_y1, wr_x2, wr_y2  in  COORD_W each  box corners (inclusive)
- wr_rgb  in  3  {r,g,b} colour
- wr_thick  in  2  border thickness minus 1 (0 gives 1 px, 3 gives 4 px)
- wr_en  in  1  slot enable
- pix_valid_out  out  1  pix_valid_in delayed by 2 cycles
- flag_out  out  1  pixel lies on an enabled box border
- rgb_out  out  3  colour of the winning box, 0 when flag_out=0
- hit_idx  out  IDX_W  winning slot, 0 when flag_out=0

Behaviour:
- Reset (asynchronous): all shadow and active slots cleared (coords 0, rgb 0, en 0). Pipeline registers, pix_valid_out, flag_out, rgb_out and hit_idx all 0. wr_ready=1.
- Write port:
  - On wr_valid && wr_ready, shadow[wr_idx] <= {coords, rgb, thick, en}.
  - wr_idx >= NUM_BOXES: the write is accepted and dropped.
  - Writes have no effect on the active set until commit.
- Commit:
  - On the frame_start cycle, active[i] <= shadow[i] for all i.
  - wr_ready=0 in the frame_start cycle, so a write and a commit never coincide.
  - A write accepted in the cycle before frame_start is included in the commit.
- Stage 1 (registered):
  - px = dot[COORD_W-1:0] - X_OFFSET, py = y_count_in[COORD_W-1:0] - Y_OFFSET, both modulo 2^COORD_W (wrap is intended; wrapped values are large and miss normal boxes).
  - The valid bit is carried alongside.
- Stage 2 (registered): per slot i, with t = thick+1:
  - inside = x1<=px<=x2 && y1<=py<=y2.
  - border = inside && (px < x1+t || px > x2-t || py < y1+t || py > y2-t). Comparisons use COORD_W+1 bits so x1+t and x2-t do not wrap.
  - hit_i = en_i && border_i && valid.
  - Degenerate box (x1>x2 or y1>y2) never hits.
  - Priority: the lowest-index hitting slot wins and drives rgb_out and hit_idx.
  - With no hit: flag_out=0, rgb_out=0, hit_idx=0.
- Latency: exactly 2 clk from pix_valid_in/dot to outputs, independent of NUM_BOXES.
- A pixel with pix_valid_in=0 produces flag_out=0 two cycles later.
- A commit mid-frame (a spurious frame_start) takes effect for pixels entering stage 2 in the following cycle; this case needs no special handling.
- Reset asserted mid-frame clears everything immediately. Outputs stay 0 until at least a write plus a frame_start.

Test Plan:
- Reset, then write slot 0 = (10,10)-(20,15), rgb=3'b100, thick=0, en=1, then pulse frame_start. Scan dot=330..340 on y_count_in=55 -> flag_out=1 and rgb_out=100 for px 10..20, 2 cycles after each input. Row py=12 -> hits only at px=10 and px=20.
- Write slot 0 without a following frame_start -> no hits. After the frame_start pulse -> hits appear. Raise wr_valid on the frame_start cycle -> wr_ready=0, and the write completes the next cycle.
- Overlap: slot 0 (0,0)-(50,50) rgb 001, slot 2 (0,0)-(30,30) rgb 010 -> at px=0,py=0: hit_idx=0, rgb 001. At px=30,py=10: hit_idx=2, rgb 010.
- thick=2 on box (100,100)-(120,120) -> px 100..102 hit and px 103 misses on row 110. Box (5,5)-(3,9) never hits. en=0 never hits.
- wr_idx=3 with NUM_BOXES=3 -> dropped, no hits. Toggle pix_valid_in -> pix_valid_out and flag_out follow with 2-cycle delay.
- Assert reset mid-scan with slots active -> outputs 0 in the same cycle. After release, no hits until rewrite plus frame_start.
